// File: rtl/enemy_draw_scheduler.sv
// rtl/enemy_draw_scheduler.sv - walks the enemy grid and issues one sprite draw per live slot
//
// Ports:
//   clk, resetn        clock and asynchronous active-low reset
//   frame_tick         one-cycle request to draw a full enemy frame
//   alive_mask [N]     bit i high = slot i is drawn (slot = row*COLS + col)
//   grid_x/grid_y      origin of slot 0, captured at frame start
//   sprite_done        completion pulse from the sprite plotter
//   sprite_enable      one-cycle start pulse to the sprite plotter
//   sprite_x/sprite_y  origin of the sprite being drawn
//   busy               high whenever the scheduler is not idle
//   frame_done         one-cycle pulse when a frame completes
//   timeout_err        sticky: a sprite never reported done
//   overrun            sticky: a frame_tick was dropped
module enemy_draw_scheduler #(
  parameter int COLS      = 5,
  parameter int ROWS      = 3,
  parameter int COL_PITCH = 32,
  parameter int ROW_PITCH = 24,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 frame_tick,
  input  logic [COLS*ROWS-1:0] alive_mask,
  input  logic [8:0]           grid_x,
  input  logic [7:0]           grid_y,
  input  logic                 sprite_done,
  output logic                 sprite_enable,
  output logic [8:0]           sprite_x,
  output logic [7:0]           sprite_y,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 timeout_err,
  output logic                 overrun
);

  localparam int N  = COLS * ROWS;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [8:0]      gx_q, gx_d;
  logic [7:0]      gy_q, gy_d;
  logic [8:0]      sprite_x_q, sprite_x_d;
  logic [7:0]      sprite_y_q, sprite_y_d;
  logic            pending_q, pending_d;
  logic            timeout_err_q, timeout_err_d;
  logic            overrun_q, overrun_d;

  logic            start_frame;
  logic            advance;
  logic            last_slot;
  logic [8:0]      x_off;
  logic [7:0]      y_off;

  // Offsets are reduced to port width before the add, so the sum wraps
  // exactly like a full-width sum truncated to 9/8 bits.
  assign x_off     = 9'(32'(col_q) * COL_PITCH);
  assign y_off     = 8'(32'(row_q) * ROW_PITCH);
  assign last_slot = (slot_q == SW'(N - 1));

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    col_d         = col_q;
    row_d         = row_q;
    tcnt_d        = tcnt_q;
    mask_d        = mask_q;
    gx_d          = gx_q;
    gy_d          = gy_q;
    sprite_x_d    = sprite_x_q;
    sprite_y_d    = sprite_y_q;
    pending_d     = pending_q;
    timeout_err_d = timeout_err_q;
    overrun_d     = overrun_q;
    start_frame   = 1'b0;
    advance       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_tick) start_frame = 1'b1;
      end
      S_SCAN: begin
        if (mask_q[slot_q]) begin
          state_d    = S_ISSUE;
          sprite_x_d = gx_q + x_off;
          sprite_y_d = gy_q + y_off;
        end else begin
          advance = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tcnt_d  = '0;
      end
      S_WAIT: begin
        if (sprite_done) begin
          advance = 1'b1;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          advance       = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DONE: begin
        // A tick arriving in this very cycle also starts the next frame.
        if (pending_q || frame_tick) start_frame = 1'b1;
        else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // One tick can be queued while busy; in DONE the queued tick is consumed
    // and a simultaneous fresh tick takes its place.
    if (state_q == S_DONE) begin
      pending_d = pending_q && frame_tick;
    end else if (state_q != S_IDLE && frame_tick) begin
      if (pending_q) overrun_d = 1'b1;
      else pending_d = 1'b1;
    end

    if (advance) begin
      if (last_slot) begin
        state_d = S_DONE;
      end else begin
        state_d = S_SCAN;
        slot_d  = slot_q + SW'(1);
        if (col_q == CW'(COLS - 1)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end

    if (start_frame) begin
      state_d = S_SCAN;
      mask_d  = alive_mask;
      gx_d    = grid_x;
      gy_d    = grid_y;
      slot_d  = '0;
      col_d   = '0;
      row_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      slot_q        <= '0;
      col_q         <= '0;
      row_q         <= '0;
      tcnt_q        <= '0;
      mask_q        <= '0;
      gx_q          <= '0;
      gy_q          <= '0;
      sprite_x_q    <= '0;
      sprite_y_q    <= '0;
      pending_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      col_q         <= col_d;
      row_q         <= row_d;
      tcnt_q        <= tcnt_d;
      mask_q        <= mask_d;
      gx_q          <= gx_d;
      gy_q          <= gy_d;
      sprite_x_q    <= sprite_x_d;
      sprite_y_q    <= sprite_y_d;
      pending_q     <= pending_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign sprite_enable = (state_q == S_ISSUE);
  assign frame_done    = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign sprite_x      = sprite_x_q;
  assign sprite_y      = sprite_y_q;
  assign timeout_err   = timeout_err_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_enemy_draw_scheduler.sv
// tb/tb_enemy_draw_scheduler.sv - self-checking bench for enemy_draw_scheduler
module tb_enemy_draw_scheduler;

  localparam int COLS = 5;
  localparam int ROWS = 3;
  localparam int N    = COLS * ROWS;

  logic         clk;
  logic         resetn;
  logic         frame_tick;
  logic [N-1:0] alive_mask;
  logic [8:0]   grid_x;
  logic [7:0]   grid_y;
  logic         sprite_done;
  logic         sprite_enable;
  logic [8:0]   sprite_x;
  logic [7:0]   sprite_y;
  logic         busy;
  logic         frame_done;
  logic         timeout_err;
  logic         overrun;

  enemy_draw_scheduler dut (
    .clk          (clk),
    .resetn       (resetn),
    .frame_tick   (frame_tick),
    .alive_mask   (alive_mask),
    .grid_x       (grid_x),
    .grid_y       (grid_y),
    .sprite_done  (sprite_done),
    .sprite_enable(sprite_enable),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .busy         (busy),
    .frame_done   (frame_done),
    .timeout_err  (timeout_err),
    .overrun      (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
  } exp_t;

  typedef struct {
    logic [N-1:0] mask;
    logic [8:0]   gx;
    logic [7:0]   gy;
    int           delay;
    int           exp_lat;
    int           exp_en;
  } vec_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   en_count   = 0;
  int   fd_count   = 0;
  int   resp_delay = 1;
  bit   resp_on    = 1'b1;
  int   resp_gen   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference placement: slot i sits at column i%COLS, row i/COLS.
  task automatic push_model(input logic [N-1:0] m, input logic [8:0] gx, input logic [7:0] gy);
    exp_t e;
    int   c;
    int   r;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        c   = i % COLS;
        r   = i / COLS;
        e.x = 9'((int'(gx) + c * 32) % 512);
        e.y = 8'((int'(gy) + r * 24) % 256);
        exp_q.push_back(e);
      end
    end
  endtask

  // Sprite plotter model: answers each enable after resp_delay cycles,
  // unless a reset happened in between.
  initial begin
    int g;
    sprite_done = 1'b0;
    forever begin
      @(negedge clk);
      if (sprite_enable && resp_on) begin
        g = resp_gen;
        repeat (resp_delay) @(negedge clk);
        if (g == resp_gen) begin
          sprite_done = 1'b1;
          @(negedge clk);
          sprite_done = 1'b0;
        end
      end
    end
  end

  // Scoreboard: every enable pops one expected coordinate pair.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sprite_enable) begin
        en_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_enable actual_x=%0d actual_y=%0d required=no enable", sprite_x, sprite_y);
        end else begin
          e = exp_q.pop_front();
          check("sprite_x", sprite_x, e.x);
          check("sprite_y", sprite_y, e.y);
        end
      end
      if (frame_done) fd_count++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame_done && cyc < budget);
    check("frame_done_seen", frame_done, 1);
  endtask

  task automatic run_frame(input logic [N-1:0] m, input logic [8:0] gx, input logic [7:0] gy,
                           output int lat, output int bc);
    @(negedge clk);
    alive_mask = m;
    grid_x     = gx;
    grid_y     = gy;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    // Inputs after capture must not influence the frame.
    alive_mask = N'($urandom);
    grid_x     = 9'($urandom);
    grid_y     = 8'($urandom);
    lat = 1;
    bc  = busy ? 1 : 0;
    while (!frame_done && lat < 20000) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
    check("frame_done_seen", frame_done, 1);
  endtask

  vec_t vecs[5];

  initial begin
    int lat;
    int bc;
    int cyc;
    int en0;
    int fd0;
    int seen;

    vecs[0] = '{mask: 15'h0000, gx: 9'd0,   gy: 8'd0,   delay: 3,   exp_lat: 16, exp_en: 0};
    vecs[1] = '{mask: 15'h7FFF, gx: 9'd10,  gy: 8'd20,  delay: 561, exp_lat: 0,  exp_en: 15};
    vecs[2] = '{mask: 15'h5555, gx: 9'd100, gy: 8'd100, delay: 1,   exp_lat: 0,  exp_en: 8};
    vecs[3] = '{mask: 15'h2A0C, gx: 9'd511, gy: 8'd255, delay: 7,   exp_lat: 0,  exp_en: 5};
    vecs[4].mask    = N'($urandom);
    vecs[4].gx      = 9'($urandom);
    vecs[4].gy      = 8'($urandom);
    vecs[4].delay   = $urandom_range(1, 20);
    vecs[4].exp_lat = 0;
    vecs[4].exp_en  = $countones(vecs[4].mask);

    resetn     = 1'b0;
    frame_tick = 1'b0;
    alive_mask = '0;
    grid_x     = '0;
    grid_y     = '0;
    #1;
    check("rst_sprite_enable", sprite_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sprite_x", sprite_x, 0);
    check("rst_sprite_y", sprite_y, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      resp_on    = 1'b1;
      resp_delay = vecs[i].delay;
      en0        = en_count;
      fd0        = fd_count;
      push_model(vecs[i].mask, vecs[i].gx, vecs[i].gy);
      run_frame(vecs[i].mask, vecs[i].gx, vecs[i].gy, lat, bc);
      @(negedge clk);
      check("idle_after_frame", busy, 0);
      #1;
      check("queue_drained", exp_q.size(), 0);
      check("enable_count", en_count - en0, vecs[i].exp_en);
      check("frame_done_count", fd_count - fd0, 1);
      if (vecs[i].exp_lat != 0) begin
        check("empty_frame_latency", lat, vecs[i].exp_lat);
        check("empty_frame_busy_cycles", bc, vecs[i].exp_lat);
      end
    end
    check("no_timeout_after_table", timeout_err, 0);
    check("no_overrun_after_table", overrun, 0);

    // Coordinate wrap at the screen edges.
    resp_delay = 2;
    exp_q.push_back('{x: 9'd500, y: 8'd250});
    exp_q.push_back('{x: 9'd116, y: 8'd42});
    run_frame(15'h4001, 9'd500, 8'd250, lat, bc);
    @(negedge clk);
    #1;
    check("wrap_queue_drained", exp_q.size(), 0);

    // Plotter never answers: timeout fires, frame still completes.
    resp_on = 1'b0;
    push_model(15'h0001, 9'd33, 8'd44);
    @(negedge clk);
    alive_mask = 15'h0001;
    grid_x     = 9'd33;
    grid_y     = 8'd44;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    cyc = 0;
    while (!sprite_enable && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_enable_seen", sprite_enable, 1);
    cyc = 0;
    while (!timeout_err && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_err_set", timeout_err, 1);
    check("timeout_latency", cyc - 1, 1023);
    wait_done(100, cyc);
    @(negedge clk);
    check("timeout_then_idle", busy, 0);
    check("timeout_err_sticky", timeout_err, 1);

    // Extra ticks during a frame: one queued, one dropped.
    resp_on    = 1'b1;
    resp_delay = 5;
    fd0        = fd_count;
    push_model(15'h0003, 9'd40, 8'd30);
    push_model(15'h0003, 9'd40, 8'd30);
    @(negedge clk);
    alive_mask = 15'h0003;
    grid_x     = 9'd40;
    grid_y     = 8'd30;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("first_extra_tick_no_overrun", overrun, 0);
    repeat (3) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("second_extra_tick_overrun", overrun, 1);
    wait_done(500, cyc);
    @(negedge clk);
    check("back_to_back_busy", busy, 1);
    wait_done(500, cyc);
    @(negedge clk);
    check("after_pending_idle", busy, 0);
    repeat (3) @(negedge clk);
    #1;
    check("pending_frame_count", fd_count - fd0, 2);
    check("pending_queue_drained", exp_q.size(), 0);

    // Reset while waiting on slot 3.
    resp_delay = 50;
    push_model(15'h000F, 9'd7, 8'd9);
    @(negedge clk);
    alive_mask = 15'h000F;
    grid_x     = 9'd7;
    grid_y     = 8'd9;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    seen = 0;
    cyc  = 0;
    while (seen < 4 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (sprite_enable) seen++;
    end
    check("slot3_issued", seen, 4);
    repeat (5) @(negedge clk);
    fd0 = fd_count;
    #2;
    resetn = 1'b0;
    resp_gen++;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_sprite_enable", sprite_enable, 0);
    check("async_rst_frame_done", frame_done, 0);
    check("async_rst_timeout_err", timeout_err, 0);
    check("async_rst_overrun", overrun, 0);
    check("async_rst_sprite_x", sprite_x, 0);
    check("async_rst_sprite_y", sprite_y, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("no_frame_done_after_reset", fd_count - fd0, 0);
    check("reset_queue_drained", exp_q.size(), 0);
    resp_delay = 1;
    push_model(15'h0009, 9'd60, 8'd70);
    run_frame(15'h0009, 9'd60, 8'd70, lat, bc);
    @(negedge clk);
    #1;
    check("restart_queue_drained", exp_q.size(), 0);
    check("restart_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
